// File: rtl/cv32e40p_x_result_wb.sv
// -----------------------------------------------------------------------------
// cv32e40p_x_result_wb
//
// Writeback stage for the x-interface result channel. Accepted coprocessor
// results go into a small circular FIFO. The head entry is written into the
// register file whenever the core pipeline leaves the shared write port free.
// Every register-file write also sends a one-cycle scoreboard-clear to the
// dispatcher. Dependent instructions are released in the same cycle the data
// lands.
//
// Parameters
//   DEPTH               number of buffered results (>= 1, any value)
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   x_result_*_i        coprocessor result channel (valid/ready handshake)
//   x_result_ready_o    a result can be accepted this cycle
//   core_wb_we_i        core owns the register-file port this cycle (priority)
//   rf_we_o/waddr/wdata register-file write port
//   sb_clr_valid_o/addr scoreboard clear, mirrors the register-file write
//   x_wb_id_o           id of the head entry (the one being written)
//   x_result_pending_o  FIFO is non-empty
//
// Handshake: a result transfers on a rising edge when x_result_valid_i and
// x_result_ready_o are both high. Ready depends only on registered state, so
// it never waits on valid. A full FIFO does not accept a result in the same
// cycle as a pop. A transferred result with we=0 or rd=x0 is acknowledged and
// dropped.
// -----------------------------------------------------------------------------
module cv32e40p_x_result_wb #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        x_result_valid_i,
  output logic        x_result_ready_o,
  input  logic [3:0]  x_result_id_i,
  input  logic [31:0] x_result_data_i,
  input  logic [4:0]  x_result_rd_i,
  input  logic        x_result_we_i,
  input  logic        core_wb_we_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        sb_clr_valid_o,
  output logic [4:0]  sb_clr_addr_o,
  output logic [3:0]  x_wb_id_o,
  output logic        x_result_pending_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    id_q   [DEPTH];
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          pending;
  logic          full;
  logic          handshake;
  logic          push;
  logic          pop;

  assign pending   = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign handshake = x_result_valid_i & ~full;
  // Results with no architectural destination are acknowledged but never stored.
  assign push      = handshake & x_result_we_i & (x_result_rd_i != 5'd0);
  // The core's own writeback wins the shared port; the head simply waits.
  assign pop       = pending & ~core_wb_we_i;

  // Pointers wrap explicitly, so DEPTH does not need to be a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so the head outputs are never X, even when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      id_q[wr_ptr_q]   <= x_result_id_i;
      rd_q[wr_ptr_q]   <= x_result_rd_i;
      data_q[wr_ptr_q] <= x_result_data_i;
    end
  end

  assign x_result_ready_o   = ~full;
  assign x_result_pending_o = pending;

  assign rf_we_o            = pop;
  assign rf_waddr_o         = rd_q[rd_ptr_q];
  assign rf_wdata_o         = data_q[rd_ptr_q];
  assign x_wb_id_o          = id_q[rd_ptr_q];

  assign sb_clr_valid_o     = pop;
  assign sb_clr_addr_o      = rd_q[rd_ptr_q];

endmodule

// File: tb/tb_cv32e40p_x_result_wb.sv
module tb_cv32e40p_x_result_wb;

  logic        clk;
  logic        rst_n;
  logic        x_valid;
  logic        x_we;
  logic [3:0]  x_id;
  logic [4:0]  x_rd;
  logic [31:0] x_data;
  logic        core_we;
  logic        en3;

  // DEPTH=2 instance outputs
  logic        rdy2, we2, sbv2, pend2;
  logic [4:0]  wa2, sba2;
  logic [31:0] wd2;
  logic [3:0]  wid2;
  // DEPTH=3 instance outputs
  logic        rdy3, we3, sbv3, pend3;
  logic [4:0]  wa3, sba3;
  logic [31:0] wd3;
  logic [3:0]  wid3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [40:0] exp2_q[$];
  logic [40:0] exp3_q[$];
  logic [40:0] e2, e3;

  cv32e40p_x_result_wb #(.DEPTH(2)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .x_result_valid_i   (x_valid),
    .x_result_ready_o   (rdy2),
    .x_result_id_i      (x_id),
    .x_result_data_i    (x_data),
    .x_result_rd_i      (x_rd),
    .x_result_we_i      (x_we),
    .core_wb_we_i       (core_we),
    .rf_we_o            (we2),
    .rf_waddr_o         (wa2),
    .rf_wdata_o         (wd2),
    .sb_clr_valid_o     (sbv2),
    .sb_clr_addr_o      (sba2),
    .x_wb_id_o          (wid2),
    .x_result_pending_o (pend2)
  );

  cv32e40p_x_result_wb #(.DEPTH(3)) dut3 (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .x_result_valid_i   (x_valid & en3),
    .x_result_ready_o   (rdy3),
    .x_result_id_i      (x_id),
    .x_result_data_i    (x_data),
    .x_result_rd_i      (x_rd),
    .x_result_we_i      (x_we),
    .core_wb_we_i       (core_we),
    .rf_we_o            (we3),
    .rf_waddr_o         (wa3),
    .rf_wdata_o         (wd3),
    .sb_clr_valid_o     (sbv3),
    .sb_clr_addr_o      (sba3),
    .x_wb_id_o          (wid3),
    .x_result_pending_o (pend3)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp2_q.delete();
      exp3_q.delete();
    end else begin
      // DEPTH=2 instance
      n_checks++;
      if (we2 !== ((exp2_q.size() != 0) && !core_we)) begin
        n_fail++;
        $display("FAIL sb2_rf_we: got %b want %b at %0t", we2, (exp2_q.size() != 0) && !core_we, $time);
      end
      n_checks++;
      if (pend2 !== (exp2_q.size() != 0) || rdy2 !== (exp2_q.size() != 2)) begin
        n_fail++;
        $display("FAIL sb2_pend_rdy: got pend=%b rdy=%b want size=%0d at %0t", pend2, rdy2, exp2_q.size(), $time);
      end
      if (we2 === 1'b1 && exp2_q.size() != 0) begin
        e2 = exp2_q.pop_front();
        n_checks++;
        if ({wid2, wa2, wd2, sbv2, sba2} !== {e2, 1'b1, e2[36:32]}) begin
          n_fail++;
          $display("FAIL sb2_write: got id=%h rd=%0d data=%h clr=%b/%0d want id=%h rd=%0d data=%h",
                   wid2, wa2, wd2, sbv2, sba2, e2[40:37], e2[36:32], e2[31:0]);
        end
      end
      if (x_valid && rdy2 && x_we && x_rd != 5'd0) exp2_q.push_back({x_id, x_rd, x_data});

      // DEPTH=3 instance
      n_checks++;
      if (we3 !== ((exp3_q.size() != 0) && !core_we)) begin
        n_fail++;
        $display("FAIL sb3_rf_we: got %b want %b at %0t", we3, (exp3_q.size() != 0) && !core_we, $time);
      end
      n_checks++;
      if (pend3 !== (exp3_q.size() != 0) || rdy3 !== (exp3_q.size() != 3)) begin
        n_fail++;
        $display("FAIL sb3_pend_rdy: got pend=%b rdy=%b want size=%0d at %0t", pend3, rdy3, exp3_q.size(), $time);
      end
      if (we3 === 1'b1 && exp3_q.size() != 0) begin
        e3 = exp3_q.pop_front();
        n_checks++;
        if ({wid3, wa3, wd3, sbv3, sba3} !== {e3, 1'b1, e3[36:32]}) begin
          n_fail++;
          $display("FAIL sb3_write: got id=%h rd=%0d data=%h clr=%b/%0d want id=%h rd=%0d data=%h",
                   wid3, wa3, wd3, sbv3, sba3, e3[40:37], e3[36:32], e3[31:0]);
        end
      end
      if (x_valid && en3 && rdy3 && x_we && x_rd != 5'd0) exp3_q.push_back({x_id, x_rd, x_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] id, input logic [4:0] rd,
                        input logic [31:0] data, input logic we);
    x_valid = v;
    x_id    = id;
    x_rd    = rd;
    x_data  = data;
    x_we    = we;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({rdy2, we2, wa2, wd2, sbv2, sba2, wid2, pend2} !==
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b we=%b wa=%0d wd=%h clr=%b/%0d id=%h pend=%b want 1 0 0 0 0/0 0 0",
               rdy2, we2, wa2, wd2, sbv2, sba2, wid2, pend2);
    end
    n_checks++;
    if ({rdy3, we3, pend3} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_outputs3: got rdy=%b we=%b pend=%b want 1 0 0", rdy3, we3, pend3);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    core_we = 1'b0;
    set_in(1'b1, 4'd3, 5'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    n_checks++;
    if (rdy2 !== 1'b1 || we2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got rdy=%b we=%b want 1 0", rdy2, we2);
    end
    cyc();
    x_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({we2, wa2, wd2, wid2, sbv2, sba2} !== {1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 1'b1, 5'd5}) begin
      n_fail++;
      $display("FAIL single_write: got we=%b wa=%0d wd=%h id=%0d clr=%b/%0d want 1 5 deadbeef 3 1/5",
               we2, wa2, wd2, wid2, sbv2, sba2);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (pend2 !== 1'b0 || we2 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drained: got pend=%b we=%b want 0 0", pend2, we2);
    end
    cyc();
  endtask

  task automatic test_discard();
    core_we = 1'b0;
    set_in(1'b1, 4'd1, 5'd7, 32'h1111_2222, 1'b0);
    @(negedge clk);
    n_checks++;
    if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL discard_rdy0: got %b want 1", rdy2); end
    cyc();
    set_in(1'b1, 4'd2, 5'd0, 32'h3333_4444, 1'b1);
    @(negedge clk);
    n_checks++;
    if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL discard_rdy1: got %b want 1", rdy2); end
    cyc();
    x_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({we2, sbv2, pend2} !== 3'b000) begin
        n_fail++;
        $display("FAIL discard_nowrite: got we=%b clr=%b pend=%b want 0 0 0", we2, sbv2, pend2);
      end
      cyc();
    end
  endtask

  task automatic test_core_priority_full();
    core_we = 1'b1;
    set_in(1'b1, 4'd1, 5'd1, 32'hA000_0001, 1'b1);
    @(negedge clk);
    n_checks++;
    if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL prio_acc1: got rdy=%b want 1", rdy2); end
    cyc();
    set_in(1'b1, 4'd2, 5'd2, 32'hA000_0002, 1'b1);
    @(negedge clk);
    n_checks++;
    if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL prio_acc2: got rdy=%b want 1", rdy2); end
    cyc();
    set_in(1'b1, 4'd3, 5'd3, 32'hA000_0003, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (rdy2 !== 1'b0 || we2 !== 1'b0) begin
        n_fail++;
        $display("FAIL prio_full_hold%0d: got rdy=%b we=%b want 0 0", i, rdy2, we2);
      end
      cyc();
    end
    core_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rdy2, we2, wa2} !== {1'b0, 1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL prio_pop1_full: got rdy=%b we=%b wa=%0d want 0 1 1", rdy2, we2, wa2);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if ({rdy2, we2, wa2} !== {1'b1, 1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL prio_pop2: got rdy=%b we=%b wa=%0d want 1 1 2", rdy2, we2, wa2);
    end
    cyc();
    x_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({we2, wa2} !== {1'b1, 5'd3}) begin
      n_fail++;
      $display("FAIL prio_pop3: got we=%b wa=%0d want 1 3", we2, wa2);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (pend2 !== 1'b0) begin n_fail++; $display("FAIL prio_empty: got pend=%b want 0", pend2); end
    cyc();
  endtask

  task automatic test_push_pop();
    core_we = 1'b1;
    set_in(1'b1, 4'd4, 5'd4, 32'hC0DE_0004, 1'b1);
    @(negedge clk);
    cyc();
    core_we = 1'b0;
    set_in(1'b1, 4'd9, 5'd9, 32'hC0DE_0009, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({rdy2, we2, wa2, wid2} !== {1'b1, 1'b1, 5'd4, 4'd4}) begin
      n_fail++;
      $display("FAIL pushpop_first: got rdy=%b we=%b wa=%0d id=%0d want 1 1 4 4", rdy2, we2, wa2, wid2);
    end
    cyc();
    x_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pend2, we2, wa2, wd2} !== {1'b1, 1'b1, 5'd9, 32'hC0DE_0009}) begin
      n_fail++;
      $display("FAIL pushpop_second: got pend=%b we=%b wa=%0d wd=%h want 1 1 9 c0de0009", pend2, we2, wa2, wd2);
    end
    cyc();
    @(negedge clk);
    cyc();
  endtask

  task automatic test_reset_mid();
    core_we = 1'b1;
    set_in(1'b1, 4'd5, 5'd11, 32'h5555_0011, 1'b1);
    cyc();
    set_in(1'b1, 4'd6, 5'd12, 32'h5555_0012, 1'b1);
    cyc();
    x_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rdy2, we2, wa2, wd2, sbv2, sba2, wid2, pend2} !==
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy=%b we=%b wa=%0d wd=%h clr=%b/%0d id=%h pend=%b want 1 0 0 0 0/0 0 0",
               rdy2, we2, wa2, wd2, sbv2, sba2, wid2, pend2);
    end
    exp2_q.delete();
    exp3_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    core_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({we2, pend2} !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset_nowrite%0d: got we=%b pend=%b want 0 0", i, we2, pend2);
      end
    end
    cyc();
  endtask

  task automatic test_wrap();
    en3     = 1'b1;
    core_we = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 4'(i), 5'(i), $urandom, 1'b1);
      @(negedge clk);
      if (i > 1) begin
        n_checks++;
        if ({we2, wa2, we3, wa3, rdy3} !== {1'b1, 5'(i - 1), 1'b1, 5'(i - 1), 1'b1}) begin
          n_fail++;
          $display("FAIL wrap_write%0d: got we2=%b wa2=%0d we3=%b wa3=%0d rdy3=%b want rd %0d",
                   i - 1, we2, wa2, we3, wa3, rdy3, i - 1);
        end
      end
      cyc();
    end
    x_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({we3, wa3} !== {1'b1, 5'd10}) begin
      n_fail++;
      $display("FAIL wrap_last: got we3=%b wa3=%0d want 1 10", we3, wa3);
    end
    cyc();
    en3 = 1'b0;
  endtask

  task automatic test_random();
    en3 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
             $urandom, $urandom_range(0, 3) != 0);
      core_we = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      cyc();
    end
    x_valid = 1'b0;
    core_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cyc();
    end
    n_checks++;
    if (exp2_q.size() != 0 || exp3_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d/%0d left want 0/0", exp2_q.size(), exp3_q.size());
    end
    en3 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n   = 1'b0;
    core_we = 1'b0;
    en3     = 1'b0;
    set_in(1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    test_reset();
    test_single();
    test_discard();
    test_core_priority_full();
    test_push_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_result_wb.md
# cv32e40p_x_result_wb

Writeback stage for the x-interface result channel, directly downstream of the x-interface dispatcher. It accepts coprocessor results, buffers them in a small FIFO, and writes them into the core register file whenever the core's own writeback does not occupy the shared write port. Each register-file write also issues a one-cycle scoreboard-clear to the dispatcher, so dependent instructions in decode are released exactly when the data lands.

## Interface
- DEPTH, 2, number of buffered results; must be at least 1; non-power-of-two values are legal.
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- x_result_valid_i  input  1  coprocessor result valid.
- x_result_ready_o  output  1  block can accept a result this cycle.
- x_result_id_i  input  4  instruction id of the result.
- x_result_data_i  input  32  result data.
- x_result_rd_i  input  5  destination register.
- x_result_we_i  input  1  result must be written to rd.
- core_wb_we_i  input  1  core pipeline is writing the register-file port this cycle; the core has priority.
- rf_we_o  output  1  register-file write enable from this block.
- rf_waddr_o  output  5  register-file write address.
- rf_wdata_o  output  32  register-file write data.
- sb_clr_valid_o  output  1  scoreboard-clear strobe to the dispatcher.
- sb_clr_addr_o  output  5  scoreboard index to clear.
- x_wb_id_o  output  4  id of the entry currently being written.
- x_result_pending_o  output  1  FIFO is non-empty.

## Operation
- **Storage**
  - Circular FIFO of DEPTH entries. Each entry holds {id, rd, data}.
  - rd_ptr and wr_ptr wrap from DEPTH-1 to 0.
  - count is $clog2(DEPTH+1) bits wide.
- **Ready**
  - x_result_ready_o = (count != DEPTH).
  - It depends only on registered state. There is no pop-through when full.
- **Accept**
  - A handshake occurs when x_result_valid_i and x_result_ready_o are both high.
  - The entry is pushed only if x_result_we_i = 1 and x_result_rd_i != 0.
  - Otherwise the result is acknowledged and discarded, with no write and no scoreboard clear.
- **Drain**
  - pop = pending & ~core_wb_we_i.
  - On pop: rf_we_o = 1, with rf_waddr_o, rf_wdata_o and x_wb_id_o taken from the head entry.
  - sb_clr_valid_o equals rf_we_o, and sb_clr_addr_o equals rf_waddr_o.
- **Output values when not popping**
  - rf_we_o and sb_clr_valid_o are 0.
  - The address, data and id outputs still show the head entry. They are don't-care when empty, but must not be X in simulation; drive from storage reset to 0.
- **Count update**
  - push and pop together: count unchanged, both pointers advance.
  - push only: count + 1.
  - pop only: count − 1.
- **Ordering**
  - Strict FIFO. Results are written in acceptance order, not by id.
- **Reset**
  - All state is cleared asynchronously: pointers, count and storage go to 0.
  - A reset mid-operation discards all buffered results.
  - Reset values of outputs: x_result_ready_o = 1, rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, sb_clr_valid_o = 0, sb_clr_addr_o = 0, x_wb_id_o = 0, x_result_pending_o = 0.

## Timing
- **Latency:** a result accepted in cycle N is written in cycle N+1 at the earliest, if core_wb_we_i = 0 in N+1. There is no same-cycle bypass.
- **Write-port stall:** each cycle with core_wb_we_i = 1 delays the head by one cycle. The FIFO holds its contents and does not drop.
- **Full boundary:** with count = DEPTH, ready is 0 in that cycle even if a pop occurs. Ready returns to 1 in the cycle after the pop.
- **Empty boundary:** with count = 0, no write is issued. A push in cycle N makes pending = 1 in N+1.
- **Combinational paths:**
  - core_wb_we_i → rf_we_o and sb_clr_valid_o only.
  - No combinational path from any x_result_* input to any output.
- **Scoreboard timing:** the clear strobe and the register-file write occur in the same cycle. The dispatcher's scoreboard bit falls at the next edge, together with the register-file update.

## Test plan
- **Single result:** after reset, x_result_valid_i=1, rd=5, data=0xDEADBEEF, we=1, id=3, with core_wb_we_i=0 → next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, x_wb_id_o=3, sb_clr_addr_o=5; the cycle after that, pending=0.
- **Discard:** we=0 with rd=7, then we=1 with rd=0 → both handshakes complete; rf_we_o and sb_clr_valid_o stay 0; pending stays 0.
- **Core priority and full:** DEPTH=2, core_wb_we_i=1 held for 4 cycles while results to rd 1, 2 and 3 are offered on consecutive cycles:
  - rd 1 and 2 are accepted, and x_result_ready_o=0 while rd 3 is held.
  - After core_wb_we_i drops, writes occur in order rd 1, then 2.
  - rd 3 is accepted one cycle after the first pop and written last.
- **Simultaneous push and pop:** with count=1 and core free, push rd=9 while rd=4 drains → count stays 1; next cycle rd=9 is written.
- **Reset mid-operation:** two results buffered, rst_ni pulsed low mid-cycle → outputs immediately take their reset values; no write of the buffered data after reset release.
- **Wrap-around:** DEPTH=3, 10 back-to-back results (rd 1–10, core free) → 10 writes in order, each one cycle after acceptance; pointers wrap 2→0 without loss.
